me_array_ctrl: RTL and testbench

Sequencer for the 32x32 PE motion-estimation array. One `start` runs three phases in order:
- Load NUM_CB current blocks, two pixels per beat.
- Prime the reference window with 32 rows.
- Sweep NUM_POS vertical search positions, issuing one absolute-difference strobe per CB at each position.

It drives every array control input and flags each valid abs result to the downstream SAD adder tree.

---
 rtl/me_array_ctrl_if.sv | 33 +++
 rtl/me_array_ctrl.sv | 174 +++++++++++++++++
 tb/tb_me_array_ctrl.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/me_array_ctrl_if.sv
// Control/handshake bundle between the ME array sequencer and its surroundings
// (pixel sources, PE array, SAD adder tree). The master side is the sequencer.
interface me_array_ctrl_if;
    logic       start;
    logic       coarse;
    logic       busy;
    logic       done;
    logic       cur_valid;
    logic       cur_ready;
    logic       ref_valid;
    logic       ref_ready;
    logic       in_curr_enable;
    logic       change_curr;
    logic [2:0] CB_select;
    logic [2:0] abs_Control;
    logic       change_ref;
    logic [1:0] ref_input_Control;
    logic       sad_valid;
    logic [2:0] sad_cb;
    logic [5:0] sad_pos;

    modport master (
        input  start, coarse, cur_valid, ref_valid,
        output busy, done, cur_ready, ref_ready, in_curr_enable, change_curr, CB_select,
               abs_Control, change_ref, ref_input_Control, sad_valid, sad_cb, sad_pos
    );

    modport slave (
        output start, coarse, cur_valid, ref_valid,
        input  busy, done, cur_ready, ref_ready, in_curr_enable, change_curr, CB_select,
               abs_Control, change_ref, ref_input_Control, sad_valid, sad_cb, sad_pos
    );
endinterface

// File: rtl/me_array_ctrl.sv
// Sequencer for the 32x32 PE motion-estimation array: loads NUM_CB current
// blocks, primes the reference window, then sweeps NUM_POS search positions
// strobing one absolute-difference result per CB at each position.
module me_array_ctrl #(
    parameter int unsigned NUM_CB        = 8,
    parameter int unsigned NUM_POS       = 16,
    parameter int unsigned ROWS          = 32,
    parameter int unsigned BEATS_PER_ROW = 16
) (
    input  logic            clk,
    input  logic            rst,
    me_array_ctrl_if.master bus
);
    localparam int unsigned BeatW = $clog2(BEATS_PER_ROW);
    localparam int unsigned RowW  = $clog2(ROWS);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(BEATS_PER_ROW - 1);
    localparam logic [RowW-1:0]  LastRow  = RowW'(ROWS - 1);
    localparam logic [2:0]       LastCb   = 3'(NUM_CB - 1);
    localparam logic [5:0]       LastPos  = 6'(NUM_POS - 1);

    // StCommit is the one-cycle change_curr slot that follows the last beat of a CB.
    typedef enum logic [2:0] {
        StIdle, StLoadCur, StCommit, StLoadRef, StSad, StShift, StDone
    } state_e;

    state_e           state_q, state_d;
    logic             coarse_q, coarse_d;
    logic [BeatW-1:0] beat_cnt_q, beat_cnt_d;
    logic [RowW-1:0]  row_cnt_q, row_cnt_d;
    logic [2:0]       cb_cnt_q, cb_cnt_d;
    logic [RowW-1:0]  ref_row_cnt_q, ref_row_cnt_d;
    logic [5:0]       pos_cnt_q, pos_cnt_d;
    logic [2:0]       abs_cnt_q, abs_cnt_d;

    logic cur_ready;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            coarse_q      <= 1'b0;
            beat_cnt_q    <= '0;
            row_cnt_q     <= '0;
            cb_cnt_q      <= '0;
            ref_row_cnt_q <= '0;
            pos_cnt_q     <= '0;
            abs_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            coarse_q      <= coarse_d;
            beat_cnt_q    <= beat_cnt_d;
            row_cnt_q     <= row_cnt_d;
            cb_cnt_q      <= cb_cnt_d;
            ref_row_cnt_q <= ref_row_cnt_d;
            pos_cnt_q     <= pos_cnt_d;
            abs_cnt_q     <= abs_cnt_d;
        end
    end

    // Next-state, counter updates and decoded array controls.
    always_comb begin
        state_d       = state_q;
        coarse_d      = coarse_q;
        beat_cnt_d    = beat_cnt_q;
        row_cnt_d     = row_cnt_q;
        cb_cnt_d      = cb_cnt_q;
        ref_row_cnt_d = ref_row_cnt_q;
        pos_cnt_d     = pos_cnt_q;
        abs_cnt_d     = abs_cnt_q;

        cur_ready             = 1'b0;
        bus.busy              = 1'b0;
        bus.done              = 1'b0;
        bus.ref_ready         = 1'b0;
        bus.change_curr       = 1'b0;
        bus.CB_select         = 3'd0;
        bus.abs_Control       = 3'd0;
        bus.change_ref        = 1'b0;
        bus.ref_input_Control = 2'd0;
        bus.sad_valid         = 1'b0;
        bus.sad_cb            = 3'd0;
        bus.sad_pos           = 6'd0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    coarse_d      = bus.coarse;
                    beat_cnt_d    = '0;
                    row_cnt_d     = '0;
                    cb_cnt_d      = '0;
                    ref_row_cnt_d = '0;
                    pos_cnt_d     = '0;
                    abs_cnt_d     = '0;
                    state_d       = StLoadCur;
                end
            end
            StLoadCur: begin
                bus.busy      = 1'b1;
                cur_ready     = 1'b1;
                bus.CB_select = cb_cnt_q;
                if (bus.cur_valid) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LastBeat) begin
                        beat_cnt_d = '0;
                        row_cnt_d  = row_cnt_q + 1'b1;
                        if (row_cnt_q == LastRow) begin
                            row_cnt_d = '0;
                            state_d   = StCommit;
                        end
                    end
                end
            end
            StCommit: begin
                bus.busy        = 1'b1;
                bus.change_curr = 1'b1;
                bus.CB_select   = cb_cnt_q;
                if (cb_cnt_q == LastCb) begin
                    cb_cnt_d      = '0;
                    ref_row_cnt_d = '0;
                    state_d       = StLoadRef;
                end else begin
                    cb_cnt_d = cb_cnt_q + 1'b1;
                    state_d  = StLoadCur;
                end
            end
            StLoadRef: begin
                bus.busy       = 1'b1;
                bus.ref_ready  = 1'b1;
                bus.change_ref = bus.ref_valid;
                if (bus.ref_valid) begin
                    ref_row_cnt_d = ref_row_cnt_q + 1'b1;
                    if (ref_row_cnt_q == LastRow) begin
                        ref_row_cnt_d = '0;
                        pos_cnt_d     = '0;
                        abs_cnt_d     = '0;
                        state_d       = StSad;
                    end
                end
            end
            StSad: begin
                bus.busy        = 1'b1;
                bus.abs_Control = abs_cnt_q;
                bus.sad_valid   = 1'b1;
                bus.sad_cb      = abs_cnt_q;
                bus.sad_pos     = pos_cnt_q;
                abs_cnt_d       = abs_cnt_q + 1'b1;
                if (abs_cnt_q == LastCb) begin
                    abs_cnt_d = '0;
                    state_d   = (pos_cnt_q == LastPos) ? StDone : StShift;
                end
            end
            StShift: begin
                bus.busy              = 1'b1;
                bus.ref_ready         = 1'b1;
                bus.change_ref        = bus.ref_valid;
                bus.ref_input_Control = coarse_q ? 2'd2 : 2'd0;
                if (bus.ref_valid) begin
                    pos_cnt_d = pos_cnt_q + 1'b1;
                    abs_cnt_d = '0;
                    state_d   = StSad;
                end
            end
            StDone: begin
                bus.done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase

        bus.cur_ready      = cur_ready;
        bus.in_curr_enable = bus.cur_valid & cur_ready;
    end
endmodule

// File: tb/tb_me_array_ctrl.sv
// Bench for me_array_ctrl: two instances (1 CB / 2 positions, 8 CBs / 4 positions)
// driven with randomized valids and checked every cycle against a step-list model.
module tb_me_array_ctrl;
    typedef enum logic [2:0] {KBeat, KCommit, KRef, KSad, KShift, KDone} kind_e;

    typedef struct packed {
        kind_e      kind;
        logic [2:0] cb;
        logic [5:0] pos;
        logic [1:0] mode;
    } step_t;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       cur_ready;
        logic       in_en;
        logic       change_curr;
        logic [2:0] cb_select;
        logic [2:0] abs_control;
        logic       ref_ready;
        logic       change_ref;
        logic [1:0] ric;
        logic       sad_valid;
        logic [2:0] sad_cb;
        logic [5:0] sad_pos;
    } out_t;

    typedef struct {
        string name;
        bit    sel;
        bit    coarse;
        int    cur_duty;
        int    ref_duty;
        int    shift_hold;
        bit    extra_start;
        int    exp_beats;
        int    exp_commits;
        int    exp_chref;
        int    exp_sad;
        int    exp_cycles;
        int    exp_hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic coarse;
    logic cur_valid;
    logic ref_valid;
    bit   sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    me_array_ctrl_if ifa ();
    me_array_ctrl_if ifb ();

    assign ifa.start     = start & ~sel;
    assign ifa.coarse    = coarse;
    assign ifa.cur_valid = cur_valid;
    assign ifa.ref_valid = ref_valid;
    assign ifb.start     = start & sel;
    assign ifb.coarse    = coarse;
    assign ifb.cur_valid = cur_valid;
    assign ifb.ref_valid = ref_valid;

    me_array_ctrl #(.NUM_CB(1), .NUM_POS(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    me_array_ctrl #(.NUM_CB(8), .NUM_POS(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    out_t act_a, act_b, act;
    assign act_a = {ifa.busy, ifa.done, ifa.cur_ready, ifa.in_curr_enable, ifa.change_curr,
                    ifa.CB_select, ifa.abs_Control, ifa.ref_ready, ifa.change_ref,
                    ifa.ref_input_Control, ifa.sad_valid, ifa.sad_cb, ifa.sad_pos};
    assign act_b = {ifb.busy, ifb.done, ifb.cur_ready, ifb.in_curr_enable, ifb.change_curr,
                    ifb.CB_select, ifb.abs_Control, ifb.ref_ready, ifb.change_ref,
                    ifb.ref_input_Control, ifb.sad_valid, ifb.sad_cb, ifb.sad_pos};
    assign act = sel ? act_b : act_a;

    // Model: the whole run as a flat list of steps; gated steps wait for their valid.
    step_t q[$];
    int    cur_duty = 100;
    int    ref_duty = 100;
    int    shift_hold = 0;
    bit    start_req = 1'b0;
    int    n_beats, n_commits, n_chref, n_sad, n_done, n_hold, cyc, done_cyc;

    task automatic build(input int ncb, input int npos, input logic crs);
        step_t s;
        q.delete();
        for (int c = 0; c < ncb; c++) begin
            for (int b = 0; b < 32 * 16; b++) begin
                s = '{KBeat, 3'(c), 6'd0, 2'd0};
                q.push_back(s);
            end
            s = '{KCommit, 3'(c), 6'd0, 2'd0};
            q.push_back(s);
        end
        for (int r = 0; r < 32; r++) begin
            s = '{KRef, 3'd0, 6'd0, 2'd0};
            q.push_back(s);
        end
        for (int p = 0; p < npos; p++) begin
            for (int c = 0; c < ncb; c++) begin
                s = '{KSad, 3'(c), 6'(p), 2'd0};
                q.push_back(s);
            end
            if (p < npos - 1) begin
                s = '{KShift, 3'd0, 6'd0, crs ? 2'd2 : 2'd0};
                q.push_back(s);
            end
        end
        s = '{KDone, 3'd0, 6'd0, 2'd0};
        q.push_back(s);
    endtask

    function automatic out_t expect_out(input logic cv, input logic rv);
        out_t e = '0;
        if (q.size() == 0) return e;
        case (q[0].kind)
            KBeat: begin
                e.busy = 1'b1; e.cur_ready = 1'b1; e.in_en = cv; e.cb_select = q[0].cb;
            end
            KCommit: begin
                e.busy = 1'b1; e.change_curr = 1'b1; e.cb_select = q[0].cb;
            end
            KRef: begin
                e.busy = 1'b1; e.ref_ready = 1'b1; e.change_ref = rv;
            end
            KSad: begin
                e.busy = 1'b1; e.abs_control = q[0].cb; e.sad_valid = 1'b1;
                e.sad_cb = q[0].cb; e.sad_pos = q[0].pos;
            end
            KShift: begin
                e.busy = 1'b1; e.ref_ready = 1'b1; e.change_ref = rv; e.ric = q[0].mode;
            end
            default: e.done = 1'b1;
        endcase
        return e;
    endfunction

    task automatic cmp(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, want);
        end
    endtask

    task automatic clear_stats();
        n_beats = 0; n_commits = 0; n_chref = 0; n_sad = 0;
        n_done = 0; n_hold = 0; cyc = 0; done_cyc = 0;
    endtask

    // One clock: drive inputs after the edge, check and advance the model mid-cycle.
    task automatic tick();
        out_t exp;
        @(posedge clk);
        #1;
        cur_valid = (int'($urandom_range(99)) < cur_duty);
        ref_valid = (int'($urandom_range(99)) < ref_duty);
        if (q.size() != 0 && q[0].kind == KShift && shift_hold > 0) begin
            ref_valid = 1'b0;
            shift_hold--;
        end
        start     = start_req;
        start_req = 1'b0;
        @(negedge clk);
        if (q.size() != 0) cyc++;
        exp = expect_out(cur_valid, ref_valid);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cycle_outputs (run cycle %0d): got %h required %h", cyc, act, exp);
        end
        n_beats   += int'(act.in_en);
        n_commits += int'(act.change_curr);
        n_chref   += int'(act.change_ref);
        n_sad     += int'(act.sad_valid);
        n_done    += int'(act.done);
        n_hold    += int'(act.ref_ready & ~act.change_ref);
        if (act.done) done_cyc = cyc;
        if (rst) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (start) begin
                build(sel ? 8 : 1, sel ? 4 : 2, coarse);
                cyc = 0;
            end
        end else begin
            case (q[0].kind)
                KBeat:       if (cur_valid) void'(q.pop_front());
                KRef, KShift: if (ref_valid) void'(q.pop_front());
                default:     void'(q.pop_front());
            endcase
        end
    endtask

    task automatic run(input vec_t v);
        int guard;
        sel        = v.sel;
        coarse     = v.coarse;
        cur_duty   = v.cur_duty;
        ref_duty   = v.ref_duty;
        shift_hold = v.shift_hold;
        clear_stats();
        start_req = 1'b1;
        tick();
        guard = 0;
        while (q.size() != 0 && guard < 30000) begin
            if (v.extra_start && cyc == 100) start_req = 1'b1;
            tick();
            guard++;
        end
        cmp({v.name, ".finished"}, int'(q.size() == 0), 1);
        q.delete();
        repeat (3) tick();
        cmp({v.name, ".beats"}, n_beats, v.exp_beats);
        cmp({v.name, ".commits"}, n_commits, v.exp_commits);
        cmp({v.name, ".change_ref"}, n_chref, v.exp_chref);
        cmp({v.name, ".sad_valid"}, n_sad, v.exp_sad);
        cmp({v.name, ".done_pulses"}, n_done, 1);
        if (v.exp_cycles >= 0) cmp({v.name, ".done_cycle"}, done_cyc, v.exp_cycles);
        if (v.exp_hold >= 0) cmp({v.name, ".shift_hold"}, n_hold, v.exp_hold);
    endtask

    vec_t tbl[5];
    vec_t after_rst;

    initial begin
        // done lands NUM_CB*513 + 32 + NUM_POS*NUM_CB + (NUM_POS-1) + 1 cycles after start
        tbl[0] = '{"nominal_1cb", 1'b0, 1'b0, 100, 100, 0, 1'b0, 512, 1, 33, 2, 549, 0};
        tbl[1] = '{"coarse_8cb", 1'b1, 1'b1, 100, 100, 0, 1'b0, 4096, 8, 35, 32, 4172, 0};
        tbl[2] = '{"random_gaps", 1'b1, 1'b0, 50, 70, 0, 1'b0, 4096, 8, 35, 32, -1, -1};
        tbl[3] = '{"start_busy", 1'b0, 1'b1, 100, 100, 0, 1'b1, 512, 1, 33, 2, 549, 0};
        tbl[4] = '{"shift_hold", 1'b0, 1'b0, 100, 100, 5, 1'b0, 512, 1, 33, 2, 554, 5};
        after_rst = '{"after_reset", 1'b0, 1'b0, 100, 100, 0, 1'b0, 512, 1, 33, 2, 549, 0};

        rst = 1'b1; start = 1'b0; coarse = 1'b0; cur_valid = 1'b0; ref_valid = 1'b0;
        sel = 1'b0;
        clear_stats();
        tick();
        sel = 1'b1;
        tick();
        rst = 1'b0;
        sel = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run(tbl[i]);

        // Reset in the middle of reference priming, at row 17.
        sel = 1'b0; coarse = 1'b0; cur_duty = 100; ref_duty = 100; shift_hold = 0;
        clear_stats();
        start_req = 1'b1;
        tick();
        for (int g = 0; g < 2000; g++) begin
            if (q.size() != 0 && q[0].kind == KRef && n_chref == 17) break;
            tick();
        end
        cmp("mid_ref.reached_row17", n_chref, 17);
        @(posedge clk);
        #1;
        cur_valid = 1'b1;
        ref_valid = 1'b1;
        #1;
        cmp("mid_ref.ref_ready_before_rst", int'(act.ref_ready), 1);
        #1;
        rst = 1'b1;
        #1;
        cmp("mid_ref.async_outputs_zero", int'(act), 0);
        q.delete();
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        tick();
        run(after_rst);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
